// File: rtl/xbus_master.sv
// rtl/xbus_master.sv - Xbus initiator; optional interrupt capture under XBUS_MASTER_INTR_EN
module xbus_master #(
  parameter logic [7:0] TIMEOUT = 8'd64
) (
  input  logic        clk,
  input  logic        reset,
`ifdef XBUS_MASTER_INTR_EN
  output logic        int_pending,
  output logic [7:0]  int_vector,
  input  logic        int_ack,
`endif
  input  logic        cmd_valid,
  input  logic        cmd_write,
  input  logic [21:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        cmd_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [21:0] addr,
  output logic [31:0] dataout,
  output logic        req,
  output logic        write,
  input  logic [31:0] datain,
  input  logic        ack,
  input  logic        decode,
  input  logic        interrupt,
  input  logic [7:0]  vector
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BUSY    = 2'd1;
  localparam logic [1:0] ST_RECOVER = 2'd2;

  logic [1:0] state;
  logic [7:0] cnt;
  logic       decode_seen;

  // Bus transaction sequencer: accept, hold req until ack or timeout, then wait out lingering ack
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      req         <= 1'b0;
      write       <= 1'b0;
      addr        <= '0;
      dataout     <= '0;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_rdata   <= '0;
      cmd_ready   <= 1'b1;
      cnt         <= '0;
      decode_seen <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            addr        <= cmd_addr;
            dataout     <= cmd_wdata;
            write       <= cmd_write;
            req         <= 1'b1;
            cnt         <= '0;
            decode_seen <= 1'b0;
            cmd_ready   <= 1'b0;
            state       <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
          end
          if (decode) begin
            decode_seen <= 1'b1;
          end
          // ack is checked first so a reply arriving on the last allowed cycle still succeeds
          if (ack) begin
            rsp_rdata <= write ? 32'd0 : datain;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            req       <= 1'b0;
            state     <= ST_RECOVER;
          end else if (cnt == TIMEOUT - 8'd1) begin
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            req       <= 1'b0;
            state     <= ST_RECOVER;
          end
        end
        ST_RECOVER: begin
          // responders may hold ack a couple of cycles after req drops; never start a new cycle over it
          if (!ack) begin
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          req       <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef XBUS_MASTER_INTR_EN
  // Interrupt capture: first vector is held until the processor acknowledges it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      int_pending <= 1'b0;
      int_vector  <= '0;
    end else if (int_ack) begin
      int_pending <= 1'b0;
    end else if (interrupt && !int_pending) begin
      int_pending <= 1'b1;
      int_vector  <= vector;
    end
  end

  logic unused_status;
  assign unused_status = decode_seen;
`else
  logic unused_inputs;
  assign unused_inputs = ^{interrupt, vector, decode_seen};
`endif

endmodule
